// File: rtl/vga_fb_reader.sv
// 160x120 RGB444 frame buffer feeding the 640x480 VGA driver with 4x upscaling,
// a valid/ready pixel write port and a full-buffer clear engine.
module vga_fb_reader #(
    parameter int          FB_W        = 160,
    parameter int          FB_H        = 120,
    parameter int          SCALE_SHIFT = 2,
    parameter logic [11:0] BLANK_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  posX,
    input  logic [8:0]  posY,
    output logic [11:0] pixel_out,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_data,
    input  logic        clr_start,
    input  logic [11:0] clr_color,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int DEPTH  = FB_W * FB_H;
    localparam int ADDR_W = 15;
    localparam int VIS_W  = FB_W << SCALE_SHIFT;
    localparam int VIS_H  = FB_H << SCALE_SHIFT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } FbState;

    FbState             state;
    logic [ADDR_W-1:0]  clrCnt;
    logic [11:0]        clrColor;
    logic               busyQ;
    logic [7:0]         dropCnt;

    logic [11:0]        mem [0:DEPTH-1];
    logic [11:0]        ramQ;
    logic               visibleQ;

    logic               visible;
    logic [9:0]         srcX;
    logic [8:0]         srcY;
    logic [ADDR_W-1:0]  rdAddr;

    logic               inRange;
    logic               accept;
    logic [ADDR_W-1:0]  wrAddrPix;
    logic               ramWe;
    logic [ADDR_W-1:0]  ramAddr;
    logic [11:0]        ramData;

    // Read side: invisible positions are steered to address 0 so the RAM index stays in range
    assign visible = (posX < 10'(VIS_W)) && (posY < 9'(VIS_H));
    assign srcX    = posX >> SCALE_SHIFT;
    assign srcY    = posY >> SCALE_SHIFT;
    assign rdAddr  = visible ? (ADDR_W'(srcY) * ADDR_W'(FB_W) + ADDR_W'(srcX)) : '0;

    assign wr_ready  = (state == IDLE) && !clr_start;
    assign accept    = wr_valid && wr_ready;
    assign inRange   = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
    assign wrAddrPix = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);

    // The clear engine owns the single write port while it runs
    always_comb begin
        ramWe   = 1'b0;
        ramAddr = wrAddrPix;
        ramData = wr_data;
        if (state == CLEAR) begin
            ramWe   = 1'b1;
            ramAddr = clrCnt;
            ramData = clrColor;
        end else if (accept && inRange) begin
            ramWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[ramAddr] <= ramData;
        end
        ramQ <= mem[rdAddr];
    end

    // Visibility travels alongside the RAM read so the blanking mux lines up with the data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            visibleQ <= 1'b0;
        end else begin
            visibleQ <= visible;
        end
    end

    assign pixel_out = visibleQ ? ramQ : BLANK_COLOR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busyQ    <= 1'b0;
            clrCnt   <= '0;
            clrColor <= '0;
            dropCnt  <= '0;
        end else begin
            if (accept && !inRange && dropCnt != 8'hFF) begin
                dropCnt <= dropCnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        busyQ    <= 1'b1;
                        clrCnt   <= '0;
                        clrColor <= clr_color;
                    end
                end
                CLEAR: begin
                    if (clrCnt == LAST_ADDR) begin
                        state  <= IDLE;
                        busyQ  <= 1'b0;
                        clrCnt <= '0;
                    end else begin
                        clrCnt <= clrCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busyQ;
    assign drop_cnt = dropCnt;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: reset, upscaled reads, blanking, drops,
// clear timing, clear/write collision and reset during a clear.
module tb_vga_fb_reader;

    logic        clk;
    logic        rst;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic [11:0] pixel_out;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        busy;
    logic [7:0]  drop_cnt;

    int checkCount;
    int errorCount;
    int busyCycles;
    logic readyLeak;

    vga_fb_reader dut (
        .clk       (clk),
        .rst       (rst),
        .posX      (posX),
        .posY      (posY),
        .pixel_out (pixel_out),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #20 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] px, input logic [8:0] py);
        @(negedge clk);
        posX = px;
        posY = py;
    endtask

    task automatic expectPixel(input string tag, input logic [9:0] px, input logic [8:0] py,
                               input logic [11:0] expected);
        applyStimulus(px, py);
        @(negedge clk);
        checkOutput(tag, {20'd0, pixel_out}, {20'd0, expected});
    endtask

    task automatic writePixel(input logic [7:0] x, input logic [6:0] y, input logic [11:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_x     = x;
        wr_y     = y;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        posX       = '0;
        posY       = '0;
        wr_valid   = 1'b0;
        wr_x       = '0;
        wr_y       = '0;
        wr_data    = '0;
        clr_start  = 1'b0;
        clr_color  = '0;
        checkCount = 0;
        errorCount = 0;

        #3 rst = 1'b0;
        #1;
        checkOutput("rstPixel", {20'd0, pixel_out}, 32'h000);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDrop", {24'd0, drop_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstReady", {31'd0, wr_ready}, 32'd1);

        writePixel(8'd5, 7'd3, 12'hF0A);
        writePixel(8'd6, 7'd3, 12'h123);
        writePixel(8'd0, 7'd4, 12'h456);

        // One buffer pixel covers a 4x4 block of screen positions
        for (int py = 12; py <= 15; py++) begin
            for (int px = 20; px <= 23; px++) begin
                expectPixel("blockRead", 10'(px), 9'(py), 12'hF0A);
            end
        end
        expectPixel("neighbourRead", 10'd24, 9'd12, 12'h123);
        expectPixel("rowBelowRead", 10'd0, 9'd16, 12'h456);

        expectPixel("blankX", 10'd640, 9'd12, 12'h000);
        expectPixel("blankY", 10'd20, 9'd480, 12'h000);
        expectPixel("blankBoth", 10'd1023, 9'd511, 12'h000);
        expectPixel("visibleAgain", 10'd23, 9'd15, 12'hF0A);

        writePixel(8'd160, 7'd3, 12'hBAD);
        writePixel(8'd5, 7'd120, 12'hBAD);
        #1;
        checkOutput("dropTwo", {24'd0, drop_cnt}, 32'd2);
        expectPixel("dropNoAlias", 10'd0, 9'd16, 12'h456);
        expectPixel("dropKeepsPixel", 10'd20, 9'd12, 12'hF0A);

        @(negedge clk);
        wr_valid = 1'b1;
        wr_x     = 8'd200;
        wr_y     = 7'd0;
        repeat (300) @(negedge clk);
        wr_valid = 1'b0;
        checkOutput("dropSaturate", {24'd0, drop_cnt}, 32'd255);

        // Clear and write arrive together; the write must wait for the clear
        @(negedge clk);
        clr_start = 1'b1;
        clr_color = 12'h0F0;
        wr_valid  = 1'b1;
        wr_x      = 8'd7;
        wr_y      = 7'd7;
        wr_data   = 12'hABC;
        #1;
        checkOutput("collideReady", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        checkOutput("clearBusy", {31'd0, busy}, 32'd1);
        checkOutput("clearReady", {31'd0, wr_ready}, 32'd0);
        checkOutput("collideNoDrop", {24'd0, drop_cnt}, 32'd255);
        busyCycles = 0;
        readyLeak  = 1'b0;
        while (busy && busyCycles < 30000) begin
            busyCycles++;
            if (wr_ready) readyLeak = 1'b1;
            @(negedge clk);
        end
        checkOutput("busyLength", busyCycles, 32'd19200);
        checkOutput("readyDuringClear", {31'd0, readyLeak}, 32'd0);
        checkOutput("readyAfterClear", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;

        expectPixel("clearFirst", 10'd0, 9'd0, 12'h0F0);
        expectPixel("clearLast", 10'd636, 9'd476, 12'h0F0);
        expectPixel("clearOverwrote", 10'd20, 9'd12, 12'h0F0);
        expectPixel("heldWrite", 10'd28, 9'd28, 12'hABC);

        applyStimulus(10'd0, 9'd0);
        clr_start = 1'b1;
        clr_color = 12'h00F;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (99) @(negedge clk);
        checkOutput("abortBusyBefore", {31'd0, busy}, 32'd1);
        checkOutput("abortPixelBefore", {20'd0, pixel_out}, 32'h00F);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortPixel", {20'd0, pixel_out}, 32'h000);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDrop", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abortReady", {31'd0, wr_ready}, 32'd1);
        checkOutput("abortIdle", {31'd0, busy}, 32'd0);
        expectPixel("partialHead", 10'd0, 9'd0, 12'h00F);
        expectPixel("partialTail", 10'd636, 9'd476, 12'h0F0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
